uart_hex_frame_rx: RTL and testbench
====================================

Name: uart_hex_frame_rx

Overview:
Parametrised UART receiver and ASCII-hex frame decoder.
- Deserialises RXD, 8N1, at a configurable clocks-per-bit rate, with input glitch filtering and stop-bit checking.
- Decodes "<BB{HH}>" frames into a bank byte and a payload register of configurable width.
- Payload is committed atomically on a valid frame only. Errors are reported with a code.
- Sits between the board UART pin and the bank/payload consumers, e.g. LED and register write logic.

Parameters:
CLKS_PER_BIT, 54, CLK cycles per UART bit (>= 8).
FILTER_LEN, 2, consecutive equal samples needed to change filtered RXD (1..15).
PAYLOAD_BYTES, 32, maximum payload bytes per frame; DATA_OUT width = 8*PAYLOAD_BYTES.
BIT_REVERSE, 1, 1: payload byte MSB lands at the lowest bit of its slot; 0: natural order.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous, active-low reset
RXD  in  1  UART line, idle high, asynchronous to CLK
DATA_OUT  out  8*PAYLOAD_BYTES  committed payload; byte k occupies bits [8k+7:8k]
BANK  out  8  committed bank byte
FRAME_VALID  out  1  one-cycle pulse; DATA_OUT/BANK updated in the same cycle
FRAME_ERR  out  1  one-cycle pulse on a frame abort
ERR_CODE  out  3  last error cause, held until the next FRAME_ERR or FRAME_VALID
BYTE_COUNT  out  $clog2(PAYLOAD_BYTES+1)  payload bytes in the last committed frame

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, ERR_CODE=0, both FSMs to IDLE, shadow registers cleared. Reset mid-frame aborts with no pulse.
- Input path: 2-flop synchroniser, then a filter. The filtered output toggles only after FILTER_LEN consecutive opposite samples. Filter reset state is 1 (idle).
- Byte FSM states:
  - IDLE: on a filtered 1->0 transition, go to START and load counter = CLKS_PER_BIT/2 - 1.
  - START: when the counter reaches 0, sample. If high, treat as a glitch and return to IDLE. If low, go to DATA with counter = CLKS_PER_BIT - 1.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample once. If high, pulse byte_valid with the byte. If low, pulse byte_ferr, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until filtered RXD = 1, then go to IDLE.
- The byte strobe occurs in the stop-sample cycle. A new start is accepted from the cycle after the strobe, so back-to-back bytes are supported.
- Frame FSM states: OUT (outside frame), BANK_HI, BANK_LO, PAY_HI, PAY_LO, DROP.
  - '<' (0x3C) in any state: clear shadow payload, nibble and byte counts; go to BANK_HI.
  - Hex char (0-9, a-f, A-F): BANK_HI -> BANK_LO -> PAY_HI. Then PAY_HI stores the high nibble and PAY_LO stores the low nibble into shadow byte[byte_cnt]; byte_cnt++.
  - '>' (0x3E) in PAY_HI: commit. DATA_OUT = shadow (unfilled bytes 0), BANK = shadow bank, BYTE_COUNT = byte_cnt, FRAME_VALID=1, ERR_CODE=0; go to OUT. A bank-only frame "<BB>" is valid with BYTE_COUNT=0.
  - '>' in BANK_HI, BANK_LO or PAY_LO: error 4 (short/odd nibble count); go to OUT.
  - Non-hex, non-delimiter char inside a frame: error 2; go to DROP.
  - Hex char in PAY_HI when byte_cnt == PAYLOAD_BYTES: error 3 (overflow); go to DROP.
  - byte_ferr inside a frame (any state except OUT/DROP): error 1; go to DROP.
  - DROP: ignore everything except '<'. '>' in DROP returns to OUT silently.
  - OUT: all bytes except '<' are ignored; byte_ferr is ignored.
- Errors: FRAME_ERR pulses one cycle and ERR_CODE is loaded in the same cycle. DATA_OUT, BANK and BYTE_COUNT keep their previous committed values.
- Latency: FRAME_VALID/FRAME_ERR are asserted on the first CLK edge after the byte strobe of the causing character.
- BIT_REVERSE=1: DATA_OUT[8k+i] = byte[7-i]. BIT_REVERSE=0: DATA_OUT[8k+i] = byte[i]. BANK is never reversed.

Decomposition:
- Package uart_hex_pkg holds:
  - ASCII constants CH_SOF=0x3C, CH_EOF=0x3E;
  - ERR_* codes (NONE=0, FRAMING=1, BADCHAR=2, OVERFLOW=3, SHORT=4);
  - the frame-state enum;
  - a hex-to-nibble function returning {valid, nibble}.
- Sub-module uart_rx_byte (synchroniser, filter, byte FSM; params CLKS_PER_BIT, FILTER_LEN; outputs byte, byte_valid, byte_ferr).
- Top level is the frame FSM plus shadow registers.

Test Plan:
- Default params except CLKS_PER_BIT=8, PAYLOAD_BYTES=4, BIT_REVERSE=0. Send "<05A1B2C3D4>" -> FRAME_VALID once; BANK=0x05; DATA_OUT=0xD4C3B2A1; BYTE_COUNT=4; ERR_CODE=0.
- Same frame with BIT_REVERSE=1 -> DATA_OUT[7:0]=0x85, DATA_OUT[31:24]=0x2B.
- Send "<07ab>" after a full frame -> BANK=0x07, DATA_OUT=0x000000AB, BYTE_COUNT=1. Then "<3A1>" -> FRAME_ERR, ERR_CODE=4, outputs unchanged.
- Send "<0011223344556>" -> FRAME_ERR with ERR_CODE=3 at the 5th payload byte's high nibble; the trailing '>' produces no pulse; a following "<01>" is valid.
- Send "<01G2>" -> ERR_CODE=2. Send a byte with the stop bit forced low inside a frame -> ERR_CODE=1. A 2-cycle low glitch on RXD while idle -> no byte decoded.
- Assert RST_N low mid-payload -> all outputs 0 immediately. After release, "<02FF>" decodes correctly.

Source files
------------

// File: rtl/uart_hex_frame_rx_pkg.sv
// Shared constants, error codes, frame-state encoding and ASCII-hex decoding
// for the UART hex frame receiver.
package uart_hex_pkg;

  localparam logic [7:0] CH_SOF = 8'h3C;
  localparam logic [7:0] CH_EOF = 8'h3E;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_FRAMING  = 3'd1;
  localparam logic [2:0] ERR_BADCHAR  = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;

  typedef enum logic [2:0] {
    FR_OUT,
    FR_BANK_HI,
    FR_BANK_LO,
    FR_PAY_HI,
    FR_PAY_LO,
    FR_DROP
  } frame_state_t;

  // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    return 5'b0_0000;
  endfunction

endpackage

// File: rtl/uart_hex_frame_rx_if.sv
// Bundle between the UART pin, the frame decoder and its bank/payload consumers.
interface uart_hex_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 32
);
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);

  logic                       RXD;
  logic [8*PAYLOAD_BYTES-1:0] DATA_OUT;
  logic [7:0]                 BANK;
  logic                       FRAME_VALID;
  logic                       FRAME_ERR;
  logic [2:0]                 ERR_CODE;
  logic [CNT_W-1:0]           BYTE_COUNT;

  modport master (input RXD, output DATA_OUT, BANK, FRAME_VALID, FRAME_ERR, ERR_CODE, BYTE_COUNT);
  modport slave  (output RXD, input DATA_OUT, BANK, FRAME_VALID, FRAME_ERR, ERR_CODE, BYTE_COUNT);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, run-length glitch filter and
// mid-bit sampling FSM. Strobes are single-cycle and registered.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 54,
  parameter int FILTER_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_ferr
);
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      FLT_LAST  = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  logic [1:0]    sync;
  logic          filt, filt_d;
  logic [3:0]    flt_cnt;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_byte = shreg;

  // Filtered line only follows the synchronised input after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= 4'd0;
    end else begin
      sync   <= {sync[0], rxd};
      filt_d <= filt;
      if (sync[1] != filt) begin
        if (flt_cnt == FLT_LAST) begin
          filt    <= sync[1];
          flt_cnt <= 4'd0;
        end else begin
          flt_cnt <= flt_cnt + 4'd1;
        end
      end else begin
        flt_cnt <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (filt_d && !filt) begin
            state <= RX_START;
            cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (filt) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg   <= {filt, shreg[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (filt) begin
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              byte_ferr <= 1'b1;
              state     <= RX_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RX_WAIT_IDLE: begin
          if (filt) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_frame_rx.sv
// UART receiver plus "<BB{HH}>" ASCII-hex frame decoder. Payload and bank are
// assembled in shadow registers and only copied to the outputs on a valid '>'.
module uart_hex_frame_rx
  import uart_hex_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 54,
  parameter int FILTER_LEN    = 2,
  parameter int PAYLOAD_BYTES = 32,
  parameter int BIT_REVERSE   = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  uart_hex_frame_rx_if.master bus
);
  localparam int               DW      = 8 * PAYLOAD_BYTES;
  localparam int               CNT_W   = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAYLOAD_BYTES);

  logic [7:0]       rx_byte;
  logic             byte_valid, byte_ferr;
  logic [4:0]       hx;
  frame_state_t     state;
  logic [DW-1:0]    sh_data;
  logic [7:0]       sh_bank;
  logic [3:0]       nib_hi;
  logic [CNT_W-1:0] byte_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FILTER_LEN  (FILTER_LEN)
  ) u_rx (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rxd       (bus.RXD),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  assign hx = hex_to_nibble(rx_byte);

  function automatic logic [DW-1:0] order_bits(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (BIT_REVERSE != 0) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++)
        for (int i = 0; i < 8; i++)
          r[8*k+i] = d[8*k+7-i];
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= FR_OUT;
      sh_data         <= '0;
      sh_bank         <= 8'd0;
      nib_hi          <= 4'd0;
      byte_cnt        <= '0;
      bus.DATA_OUT    <= '0;
      bus.BANK        <= 8'd0;
      bus.FRAME_VALID <= 1'b0;
      bus.FRAME_ERR   <= 1'b0;
      bus.ERR_CODE    <= ERR_NONE;
      bus.BYTE_COUNT  <= '0;
    end else begin
      bus.FRAME_VALID <= 1'b0;
      bus.FRAME_ERR   <= 1'b0;
      if (byte_ferr) begin
        if (state != FR_OUT && state != FR_DROP) begin
          bus.FRAME_ERR <= 1'b1;
          bus.ERR_CODE  <= ERR_FRAMING;
          state         <= FR_DROP;
        end
      end else if (byte_valid) begin
        if (rx_byte == CH_SOF) begin
          sh_data  <= '0;
          sh_bank  <= 8'd0;
          byte_cnt <= '0;
          state    <= FR_BANK_HI;
        end else if (rx_byte == CH_EOF) begin
          if (state == FR_PAY_HI) begin
            bus.DATA_OUT    <= order_bits(sh_data);
            bus.BANK        <= sh_bank;
            bus.BYTE_COUNT  <= byte_cnt;
            bus.FRAME_VALID <= 1'b1;
            bus.ERR_CODE    <= ERR_NONE;
          end else if (state != FR_OUT && state != FR_DROP) begin
            bus.FRAME_ERR <= 1'b1;
            bus.ERR_CODE  <= ERR_SHORT;
          end
          state <= FR_OUT;
        end else if (state == FR_OUT || state == FR_DROP) begin
          state <= state;
        end else if (!hx[4]) begin
          bus.FRAME_ERR <= 1'b1;
          bus.ERR_CODE  <= ERR_BADCHAR;
          state         <= FR_DROP;
        end else begin
          case (state)
            FR_BANK_HI: begin
              sh_bank[7:4] <= hx[3:0];
              state        <= FR_BANK_LO;
            end
            FR_BANK_LO: begin
              sh_bank[3:0] <= hx[3:0];
              state        <= FR_PAY_HI;
            end
            FR_PAY_HI: begin
              if (byte_cnt == CNT_MAX) begin
                bus.FRAME_ERR <= 1'b1;
                bus.ERR_CODE  <= ERR_OVERFLOW;
                state         <= FR_DROP;
              end else begin
                nib_hi <= hx[3:0];
                state  <= FR_PAY_LO;
              end
            end
            FR_PAY_LO: begin
              for (int k = 0; k < PAYLOAD_BYTES; k++)
                if (byte_cnt == CNT_W'(k)) sh_data[8*k +: 8] <= {nib_hi, hx[3:0]};
              byte_cnt <= byte_cnt + CNT_W'(1);
              state    <= FR_PAY_HI;
            end
            default: state <= FR_OUT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_frame_rx.sv
// Drives two decoders (natural and bit-reversed payload) from one serial line
// and compares them against a string-level frame model.
module tb_uart_hex_frame_rx;
  localparam int CPB = 8;
  localparam int PB  = 4;
  localparam int GAP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;

  always #5 clk = ~clk;

  uart_hex_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus_nat ();
  uart_hex_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus_rev ();
  assign bus_nat.RXD = rxd;
  assign bus_rev.RXD = rxd;

  uart_hex_frame_rx #(.CLKS_PER_BIT(CPB), .FILTER_LEN(2), .PAYLOAD_BYTES(PB), .BIT_REVERSE(0))
    dut_nat (.CLK(clk), .RST_N(rst_n), .bus(bus_nat));
  uart_hex_frame_rx #(.CLKS_PER_BIT(CPB), .FILTER_LEN(2), .PAYLOAD_BYTES(PB), .BIT_REVERSE(1))
    dut_rev (.CLK(clk), .RST_N(rst_n), .bus(bus_rev));

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters observed on the DUT outputs
  int nv_nat = 0, ne_nat = 0, nv_rev = 0, ne_rev = 0;
  always @(posedge clk) begin
    if (bus_nat.FRAME_VALID) nv_nat++;
    if (bus_nat.FRAME_ERR)   ne_nat++;
    if (bus_rev.FRAME_VALID) nv_rev++;
    if (bus_rev.FRAME_ERR)   ne_rev++;
  end

  // Reference model state: text received since the last '<', as nibble values
  bit          m_in = 1'b0;
  int          m_buf[$];
  logic [7:0]  m_bank = 8'd0;
  logic [31:0] m_data = 32'd0, m_drev = 32'd0;
  int          m_cnt = 0, m_err = 0, m_nv = 0, m_ne = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] flip8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic model_err(input int code);
    m_err = code;
    m_ne++;
    m_in = 1'b0;
  endtask

  task automatic model_char(input logic [7:0] c);
    int n;
    logic [7:0] b;
    if (c == 8'h3C) begin
      m_in = 1'b1;
      m_buf.delete();
    end else if (m_in) begin
      if (c == 8'h3E) begin
        if (m_buf.size() >= 2 && m_buf.size() % 2 == 0) begin
          m_in   = 1'b0;
          m_bank = 8'(m_buf[0] * 16 + m_buf[1]);
          n      = (m_buf.size() - 2) / 2;
          m_data = 32'd0;
          m_drev = 32'd0;
          for (int k = 0; k < n; k++) begin
            b = 8'(m_buf[2+2*k] * 16 + m_buf[3+2*k]);
            m_data = m_data | (32'(b) << (8 * k));
            m_drev = m_drev | (32'(flip8(b)) << (8 * k));
          end
          m_cnt = n;
          m_err = 0;
          m_nv++;
        end else begin
          model_err(4);
        end
      end else if (hex_val(c) < 0) begin
        model_err(2);
      end else if (m_buf.size() >= 2 + 2 * PB && m_buf.size() % 2 == 0) begin
        model_err(3);
      end else begin
        m_buf.push_back(hex_val(c));
      end
    end
  endtask

  task automatic model_reset();
    m_in = 1'b0;
    m_buf.delete();
    m_bank = 8'd0;
    m_data = 32'd0;
    m_drev = 32'd0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":valid_n"}, 32'(nv_nat), 32'(m_nv));
    check_eq({tag, ":err_n"},   32'(ne_nat), 32'(m_ne));
    check_eq({tag, ":bank"},    32'(bus_nat.BANK), 32'(m_bank));
    check_eq({tag, ":data"},    bus_nat.DATA_OUT, m_data);
    check_eq({tag, ":count"},   32'(bus_nat.BYTE_COUNT), 32'(m_cnt));
    check_eq({tag, ":code"},    32'(bus_nat.ERR_CODE), 32'(m_err));
    check_eq({tag, ":r_valid_n"}, 32'(nv_rev), 32'(m_nv));
    check_eq({tag, ":r_err_n"},   32'(ne_rev), 32'(m_ne));
    check_eq({tag, ":r_bank"},    32'(bus_rev.BANK), 32'(m_bank));
    check_eq({tag, ":r_data"},    bus_rev.DATA_OUT, m_drev);
    check_eq({tag, ":r_count"},   32'(bus_rev.BYTE_COUNT), 32'(m_cnt));
    check_eq({tag, ":r_code"},    32'(bus_rev.ERR_CODE), 32'(m_err));
  endtask

  task automatic uart_tx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_char(input logic [7:0] c, input string tag);
    uart_tx(c, 1'b1);
    model_char(c);
    repeat (GAP) @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_ferr(input string tag);
    uart_tx(8'($urandom_range(0, 255)), 1'b0);
    if (m_in) model_err(1);
    repeat (GAP + CPB) @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_glitch(input string tag);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (GAP + CPB) @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_char(s[i], tag);
  endtask

  function automatic int hex_char(input int v);
    if (v < 10) return 48 + v;
    return (($urandom_range(0, 1) != 0) ? 97 : 65) + v - 10;
  endfunction

  // Items: 0..255 = character, -1 = framing-error byte, -2 = short line glitch
  task automatic rand_frame(input int idx);
    int fr[$];
    int n, mode, pos;
    if ($urandom_range(0, 3) == 0) fr.push_back($urandom_range(0, 255));
    fr.push_back(8'h3C);
    fr.push_back(hex_char($urandom_range(0, 15)));
    fr.push_back(hex_char($urandom_range(0, 15)));
    n = $urandom_range(0, PB + 1);
    for (int k = 0; k < 2 * n; k++) fr.push_back(hex_char($urandom_range(0, 15)));
    mode = $urandom_range(0, 7);
    pos  = $urandom_range(1, fr.size() - 1);
    case (mode)
      0: fr[pos] = $urandom_range(0, 255);
      1: void'(fr.pop_back());
      2: fr.insert(pos, -1);
      3: fr.insert(pos, -2);
      default: ;
    endcase
    fr.push_back(8'h3E);
    foreach (fr[i]) begin
      if (fr[i] == -1)      send_ferr($sformatf("rnd%0d_ferr", idx));
      else if (fr[i] == -2) send_glitch($sformatf("rnd%0d_glitch", idx));
      else                  send_char(8'(fr[i]), $sformatf("rnd%0d", idx));
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    repeat (3) @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all("after_reset");

    send_str("<05A1B2C3D4>", "full");
    check_eq("full_data", bus_nat.DATA_OUT, 32'hD4C3B2A1);
    check_eq("full_bank", 32'(bus_nat.BANK), 32'h05);
    check_eq("full_count", 32'(bus_nat.BYTE_COUNT), 32'd4);
    check_eq("rev_low", 32'(bus_rev.DATA_OUT[7:0]), 32'h85);
    check_eq("rev_high", 32'(bus_rev.DATA_OUT[31:24]), 32'h2B);

    send_str("<07ab>", "short_frame");
    check_eq("short_data", bus_nat.DATA_OUT, 32'h000000AB);
    send_str("<3A1>", "odd");
    check_eq("odd_code", 32'(bus_nat.ERR_CODE), 32'd4);
    check_eq("odd_bank", 32'(bus_nat.BANK), 32'h07);

    send_str("<0011223344556>", "ovf");
    check_eq("ovf_code", 32'(bus_nat.ERR_CODE), 32'd3);
    send_str("<01>", "bank_only");
    check_eq("bank_only_cnt", 32'(bus_nat.BYTE_COUNT), 32'd0);

    send_str("<01G2>", "badchar");
    check_eq("badchar_code", 32'(bus_nat.ERR_CODE), 32'd2);
    send_str("<01", "ferr_pre");
    send_ferr("ferr");
    check_eq("ferr_code", 32'(bus_nat.ERR_CODE), 32'd1);
    send_str("<01", "glitch_pre");
    send_glitch("glitch");
    send_str("23>", "glitch_post");
    check_eq("glitch_data", bus_nat.DATA_OUT, 32'h00000023);

    // Back-to-back characters with no idle time between stop and start bits
    s = "<9Cbeef>";
    for (int i = 0; i < s.len(); i++) begin
      uart_tx(s[i], 1'b1);
      model_char(s[i]);
    end
    repeat (GAP) @(negedge clk);
    check_all("b2b");

    for (int f = 0; f < 20; f++) rand_frame(f);

    send_str("<02AB", "pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_data", bus_nat.DATA_OUT, 32'd0);
    check_eq("rst_bank", 32'(bus_nat.BANK), 32'd0);
    check_eq("rst_count", 32'(bus_nat.BYTE_COUNT), 32'd0);
    check_eq("rst_code", 32'(bus_rev.ERR_CODE), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_str("<02FF>", "post_rst");
    check_eq("post_rst_data", bus_nat.DATA_OUT, 32'h000000FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
